// File: rtl/uart_tx_core.sv
// uart_tx_core: UART transmitter. Serialises one latched byte per handshake as
// start(0), data LSB-first, optional parity, stop(1). Each bit lasts Prescale
// clock cycles (minimum 4). TX_OUT and busy are registered, with no
// combinational path from any input.
module uart_tx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 5
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESC_W-1:0]    Prescale,
    output logic                  TX_OUT,
    output logic                  busy
);

    localparam int BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [PRESC_W-1:0]    r_edge_cnt;
    logic [PRESC_W-1:0]    w_edge_cnt_next;
    logic [BIT_W-1:0]      r_bit_cnt;
    logic [BIT_W-1:0]      w_bit_cnt_next;

    // Shadow copies of the request, frozen for the whole frame
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_en;
    logic                  r_par_typ;
    logic [PRESC_W-1:0]    r_presc;

    logic                  r_tx;
    logic                  r_busy;
    logic                  w_tx_next;
    logic                  w_busy_next;
    logic                  w_accept;
    logic                  w_last_edge;
    logic                  w_last_bit;
    logic [PRESC_W-1:0]    w_presc_clamped;

    // Busy is low exactly when the FSM is idle, so idle alone qualifies a request
    assign w_accept        = Data_Valid && (r_state == S_IDLE);
    assign w_last_edge     = (r_edge_cnt == (r_presc - PRESC_W'(1)));
    assign w_last_bit      = (r_bit_cnt == BIT_W'(DATA_WIDTH - 1));
    assign w_presc_clamped = (Prescale < PRESC_W'(4)) ? PRESC_W'(4) : Prescale;

    // Next state, counters and the registered line/busy values for the next cycle
    always_comb begin
        w_state_next    = r_state;
        w_edge_cnt_next = r_edge_cnt;
        w_bit_cnt_next  = r_bit_cnt;
        w_tx_next       = 1'b1;
        w_busy_next     = 1'b0;

        if (r_state == S_IDLE) begin
            w_edge_cnt_next = '0;
            w_bit_cnt_next  = '0;
            if (w_accept) begin
                w_state_next = S_START;
            end
        end else if (w_last_edge) begin
            w_edge_cnt_next = '0;
            case (r_state)
                S_START: begin
                    w_state_next   = S_DATA;
                    w_bit_cnt_next = '0;
                end
                S_DATA: begin
                    if (w_last_bit) begin
                        w_state_next   = r_par_en ? S_PARITY : S_STOP;
                        w_bit_cnt_next = '0;
                    end else begin
                        w_bit_cnt_next = r_bit_cnt + BIT_W'(1);
                    end
                end
                S_PARITY: w_state_next = S_STOP;
                S_STOP:   w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end else begin
            w_edge_cnt_next = r_edge_cnt + PRESC_W'(1);
        end

        // Output mux driven from the upcoming state so the registered line lines up with it
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = r_data[w_bit_cnt_next];
            S_PARITY: w_tx_next = (^r_data) ^ r_par_typ;
            default:  w_tx_next = 1'b1;
        endcase
        w_busy_next = (w_state_next != S_IDLE);
    end

    // State, counters and registered outputs; reset aborts any frame immediately
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state    <= S_IDLE;
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_edge_cnt <= w_edge_cnt_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_tx       <= w_tx_next;
            r_busy     <= w_busy_next;
        end
    end

    // Capture the request on the accept cycle; inputs are free to change afterwards
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_data    <= '0;
            r_par_en  <= 1'b0;
            r_par_typ <= 1'b0;
            r_presc   <= '0;
        end else if (w_accept) begin
            r_data    <= P_DATA;
            r_par_en  <= PAR_EN;
            r_par_typ <= PAR_TYP;
            r_presc   <= w_presc_clamped;
        end
    end

    assign TX_OUT = r_tx;
    assign busy   = r_busy;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: directed bench for uart_tx_core. Expected frames are pushed
// to a scoreboard when a request is driven and popped while the serial line is
// checked bit by bit, together with busy and the idle cycle after each frame.
module tb_uart_tx_core;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [4:0] Prescale;
    logic       TX_OUT;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       pt;
        int         p;
    } frame_t;

    frame_t sb[$];
    int errors = 0;
    int checks = 0;

    uart_tx_core #(.DATA_WIDTH(8), .PRESC_W(5)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .Prescale   (Prescale),
        .TX_OUT     (TX_OUT),
        .busy       (busy)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Drive a request for one accept cycle; optionally record the frame it should produce
    task automatic drive_req(input logic [7:0] d, input logic pe, input logic pt,
                             input logic [4:0] presc, input bit push);
        frame_t f;
        if (push) begin
            f.data = d;
            f.pe   = pe;
            f.pt   = pt;
            f.p    = (presc < 5'd4) ? 4 : int'(presc);
            sb.push_back(f);
        end
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Prescale   = presc;
        Data_Valid = 1'b1;
    endtask

    // Called at the first start-bit cycle; checks the whole frame and the idle cycle after it
    task automatic capture(input string tag, input int inject_at);
        frame_t      f;
        logic [10:0] bits;
        logic        tx_obs;
        logic        busy_obs;
        int          n;
        int          k;
        check({tag, " scoreboard_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() == 0) return;
        f = sb.pop_front();
        n = f.pe ? 11 : 10;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = f.data[i];
        if (f.pe) bits[9] = (^f.data) ^ f.pt;
        k = 0;
        for (int b = 0; b < n; b++) begin
            tx_obs   = bits[b];
            busy_obs = 1'b1;
            for (int c = 0; c < f.p; c++) begin
                if (TX_OUT !== bits[b]) tx_obs = TX_OUT;
                if (busy !== 1'b1) busy_obs = busy;
                if (inject_at >= 0 && k == inject_at) begin
                    Data_Valid = 1'b1;
                    P_DATA     = 8'h3C;
                end else if (inject_at >= 0 && k == inject_at + 1) begin
                    Data_Valid = 1'b0;
                end
                tick();
                k++;
            end
            check($sformatf("%s bit%0d tx", tag, b), 32'(tx_obs), 32'(bits[b]));
            check($sformatf("%s bit%0d busy", tag, b), 32'(busy_obs), 32'd1);
        end
        check({tag, " end busy"}, 32'(busy), 32'd0);
        check({tag, " end tx"}, 32'(TX_OUT), 32'd1);
        $display("txn %s data=%02h par_en=%0d par_typ=%0d presc=%0d cycles=%0d",
                 tag, f.data, f.pe, f.pt, f.p, k);
    endtask

    task automatic send_frame(input string tag, input logic [7:0] d, input logic pe,
                              input logic pt, input logic [4:0] presc, input int inject_at);
        check({tag, " idle before request"}, 32'(busy), 32'd0);
        drive_req(d, pe, pt, presc, 1'b1);
        tick();
        Data_Valid = 1'b0;
        capture(tag, inject_at);
    endtask

    // Line must stay idle for n cycles
    task automatic idle_check(input string tag, input int n);
        logic tx_obs;
        logic busy_obs;
        tx_obs   = 1'b1;
        busy_obs = 1'b0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (TX_OUT !== 1'b1) tx_obs = TX_OUT;
            if (busy !== 1'b0) busy_obs = busy;
        end
        check({tag, " idle tx"}, 32'(tx_obs), 32'd1);
        check({tag, " idle busy"}, 32'(busy_obs), 32'd0);
        $display("txn %s idle for %0d cycles", tag, n);
    endtask

    initial begin
        RST        = 1'b1;
        P_DATA     = 8'h00;
        Data_Valid = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = 1'b0;
        Prescale   = 5'd8;

        // Reset held three cycles, then quiet line
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("reset%0d tx", i), 32'(TX_OUT), 32'd1);
            check($sformatf("reset%0d busy", i), 32'(busy), 32'd0);
        end
        RST = 1'b0;
        idle_check("post_reset", 8);

        // Even parity, 8 cycles per bit
        send_frame("a5_even_p8", 8'hA5, 1'b1, 1'b0, 5'd8, -1);
        tick();

        // Odd parity on zero byte, then the same byte without parity
        send_frame("00_odd_p16", 8'h00, 1'b1, 1'b1, 5'd16, -1);
        tick();
        send_frame("00_nopar_p16", 8'h00, 1'b0, 1'b0, 5'd16, -1);
        tick();

        // Request pulsed mid-frame must be dropped
        send_frame("ff_with_drop", 8'hFF, 1'b1, 1'b0, 5'd4, 20);
        idle_check("after_drop", 6);

        // Data_Valid held high: two frames with exactly one idle cycle between them
        drive_req(8'h12, 1'b1, 1'b1, 5'd5, 1'b1);
        tick();
        drive_req(8'h34, 1'b1, 1'b1, 5'd5, 1'b1);
        capture("hold_12", -1);
        tick();
        Data_Valid = 1'b0;
        P_DATA     = 8'hEE;
        capture("hold_34", -1);
        idle_check("after_hold", 4);

        // Reset during data bit 3 aborts the frame on the next cycle
        drive_req(8'hC3, 1'b0, 1'b0, 5'd4, 1'b0);
        tick();
        Data_Valid = 1'b0;
        repeat (17) tick();
        check("abort data bit3 tx", 32'(TX_OUT), 32'd0);
        check("abort data bit3 busy", 32'(busy), 32'd1);
        RST = 1'b1;
        tick();
        check("abort tx", 32'(TX_OUT), 32'd1);
        check("abort busy", 32'(busy), 32'd0);
        RST = 1'b0;
        idle_check("after_abort", 5);
        send_frame("5a_after_abort", 8'h5A, 1'b1, 1'b0, 5'd4, -1);
        tick();

        // Reset and request on the same cycle: reset wins
        RST = 1'b1;
        drive_req(8'h77, 1'b0, 1'b0, 5'd4, 1'b0);
        tick();
        RST        = 1'b0;
        Data_Valid = 1'b0;
        check("rst_vs_req tx", 32'(TX_OUT), 32'd1);
        check("rst_vs_req busy", 32'(busy), 32'd0);
        idle_check("after_rst_vs_req", 5);

        // Prescale below 4 clamps to 4
        send_frame("96_p2_clamp", 8'h96, 1'b1, 1'b1, 5'd2, -1);
        tick();
        send_frame("69_p0_clamp", 8'h69, 1'b0, 1'b0, 5'd0, -1);
        tick();

        // Random bytes and frame options
        for (int i = 0; i < 256; i++) begin
            send_frame($sformatf("rand%0d", i), 8'($urandom_range(0, 255)),
                       1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(4, 6)), -1);
        end
        idle_check("final", 4);
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
